// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard for the integer register file: per-register pending-write counters gate issue.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle write-back clear a source hazard on a count of 1.
module regfile_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_we,
  input  logic [4:0]      issue_rs1,
  input  logic            issue_rs1_used,
  input  logic [4:0]      issue_rs2,
  input  logic            issue_rs2_used,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  output logic [NREG-1:0] busy,
  output logic [15:0]     stall_count,
  output logic            err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [15:0]      stall_q;
  logic             err_q;

  logic hz_rs1, hz_rs2, hz_sat, fire, underflow, stall_inc;

  always_comb begin
    hz_rs1 = issue_rs1_used && (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0);
    hz_rs2 = issue_rs2_used && (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    // The register file forwards a same-cycle write, so the last pending write landing now is safe to read.
    if (wb_valid && (wb_rd == issue_rs1) && (cnt_q[issue_rs1] == CNT_W'(1)))
      hz_rs1 = 1'b0;
    if (wb_valid && (wb_rd == issue_rs2) && (cnt_q[issue_rs2] == CNT_W'(1)))
      hz_rs2 = 1'b0;
`endif
    // Saturation looks at the current count only; a retire this cycle does not unblock it.
    hz_sat = issue_rd_we && (issue_rd != 5'd0) && (cnt_q[issue_rd] == CNT_MAX);
  end

  assign issue_ready = !halt && !hz_rs1 && !hz_rs2 && !hz_sat;
  assign fire        = issue_valid && issue_ready;
  assign stall_inc   = issue_valid && !issue_ready && !halt;

  always_comb begin
    underflow = 1'b0;
    busy_d    = '0;
    for (int r = 0; r < NREG; r++) begin
      logic           inc;
      logic [CNT_W:0] dec;
      logic [CNT_W:0] sum;
      inc = fire && issue_rd_we && (issue_rd == 5'(r));
      dec = (CNT_W+1)'(wb_valid && (wb_rd == 5'(r)))
          + (CNT_W+1)'(kill_valid && (kill_rd == 5'(r)));
      sum = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (sum < dec) begin
        cnt_d[r]  = '0;
        underflow = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(sum - dec);
      end
      busy_d[r] = (r != 0) && (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      busy_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else if (!halt) begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (underflow) err_q <= 1'b1;
    end
  end

  assign busy          = busy_q;
  assign stall_count   = stall_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a per-register pending-count model checked every cycle.
module tb_regfile_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk, reset, halt, issue_valid, issue_rd_we, issue_rs1_used, issue_rs2_used;
  logic        wb_valid, kill_valid, issue_ready, err_underflow;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, wb_rd, kill_rd;
  logic [31:0] busy;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  int m_cnt [32];
  int m_stall;
  bit m_err;

  regfile_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .busy(busy), .stall_count(stall_count), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a source is blocked while any write to it is still outstanding.
  function automatic bit src_blocked(bit used, int r);
    if (!used || r == 0 || m_cnt[r] == 0) return 1'b0;
    if (BYP == 1 && m_cnt[r] == 1 && wb_valid && int'(wb_rd) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    if (halt) return 1'b0;
    if (src_blocked(issue_rs1_used, int'(issue_rs1))) return 1'b0;
    if (src_blocked(issue_rs2_used, int'(issue_rs2))) return 1'b0;
    if (issue_rd_we && issue_rd != 0 && m_cnt[int'(issue_rd)] == 3) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nxt(int r);
    int n = m_cnt[r];
    if (issue_valid && m_ready() && issue_rd_we && int'(issue_rd) == r) n++;
    if (wb_valid && int'(wb_rd) == r) n--;
    if (kill_valid && int'(kill_rd) == r) n--;
    return n;
  endfunction

  function automatic bit any_under();
    for (int r = 1; r < 32; r++) if (nxt(r) < 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
      m_stall <= 0;
      m_err   <= 1'b0;
    end else if (!halt) begin
      for (int r = 1; r < 32; r++) m_cnt[r] <= (nxt(r) < 0) ? 0 : nxt(r);
      if (issue_valid && !m_ready() && m_stall < 65535) m_stall <= m_stall + 1;
      if (any_under()) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready", issue_ready, m_ready());
    chk("busy", busy, m_busy());
    chk("stall_count", stall_count, m_stall);
    chk("err_underflow", err_underflow, m_err);
  end

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_rd_we = 0;
    issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
    wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
  endtask

  task automatic iss(input logic [4:0] rd, input logic we, input logic [4:0] rs1, input logic u1);
    issue_valid = 1; issue_rd = rd; issue_rd_we = we;
    issue_rs1 = rs1; issue_rs1_used = u1; issue_rs2 = 0; issue_rs2_used = 0;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1; wb_rd = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int stalls;
    bit fired;
    logic [15:0] sc;
    logic [31:0] bz;

    idle(); halt = 0; reset = 1;
    repeat (2) tick();
    reset = 0;
    mid(); chk("rst_busy", busy, 32'd0); chk("rst_ready", issue_ready, 1);
    tick();

    // RAW: A writes x5, B reads x5, wb x5 on the third cycle after A fires
    iss(5, 1, 0, 0); mid(); chk("raw_a_ready", issue_ready, 1); tick();
    idle(); iss(0, 0, 5, 1);
    stalls = 0; fired = 0;
    for (int c = 1; c <= 10 && !fired; c++) begin
      wb_valid = (c == 3); wb_rd = 5;
      mid();
      if (issue_ready) fired = 1; else stalls++;
      tick();
    end
    chk("raw_fired", fired, 1);
    chk("raw_stalls", stalls, (BYP == 1) ? 2 : 3);
    idle(); mid();
    chk("raw_stall_count", stall_count, (BYP == 1) ? 2 : 3);
    chk("raw_busy", busy, 32'd0);
    tick();

    // x0 is never tracked
    iss(0, 1, 0, 0); tick();
    idle(); iss(0, 0, 0, 1); wb(0);
    mid(); chk("x0_ready", issue_ready, 1); tick();
    idle(); mid(); chk("x0_busy", busy, 32'd0); chk("x0_err", err_underflow, 0); tick();

    // Saturation on x7 with same-cycle retire, then wb+kill together
    for (int i = 0; i < 3; i++) begin iss(7, 1, 0, 0); tick(); end
    iss(7, 1, 0, 0); wb(7);
    mid(); chk("sat_ready", issue_ready, 0); tick();
    wb_valid = 0;
    mid(); chk("sat_resume", issue_ready, 1); tick();
    idle(); wb(7); tick();
    wb(7); kill_valid = 1; kill_rd = 7;
    mid(); chk("sat_busy7_pre", busy[7], 1); tick();
    idle(); mid(); chk("sat_busy7", busy[7], 0); chk("sat_err", err_underflow, 0); tick();

    // Underflow on x9 is sticky
    kill_valid = 1; kill_rd = 9; tick();
    idle(); mid(); chk("uf_err", err_underflow, 1); chk("uf_busy", busy, 32'd0);
    repeat (3) tick();
    mid(); chk("uf_sticky", err_underflow, 1); tick();

    // Halt for 4 cycles with x3 pending
    iss(3, 1, 0, 0); tick();
    idle(); mid(); sc = stall_count; bz = busy; chk("halt_busy3", bz[3], 1); tick();
    halt = 1; iss(0, 0, 3, 1); wb(3);
    repeat (4) begin
      mid();
      chk("halt_ready", issue_ready, 0);
      chk("halt_stall", stall_count, sc);
      chk("halt_busy", busy, bz);
      tick();
    end
    halt = 0; mid(); tick();
    idle(); mid(); chk("halt_done_busy", busy, 32'd0); tick();

    // Asynchronous reset mid-cycle with cnt[x5] = 2
    iss(5, 1, 0, 0); tick(); tick();
    idle(); mid(); chk("pre_rst_busy5", busy[5], 1);
    #2 reset = 1;
    #1;
    chk("arst_busy", busy, 32'd0);
    chk("arst_stall", stall_count, 16'd0);
    chk("arst_err", err_underflow, 0);
    chk("arst_ready", issue_ready, 1);
    tick(); tick();
    reset = 0;
    wb(5); tick();
    idle(); mid(); chk("post_rst_uf", err_underflow, 1); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Issue-stage scoreboard for the 32-entry integer register file of the pipelined RISC-V core. Tracks in-flight writes per destination register with small counters and holds issue (`issue_ready` low) while a source operand or a saturated destination has a write pending. Counters are retired by write-back or squash (kill). The block sequences access to the register file so that reads never return stale data.

## Interface

Parameters:
- `NREG`, 32: number of architectural registers. x0 is hardwired and never tracked.
- `CNT_W`, 2: pending-counter width. Allows up to 2^CNT_W-1 in-flight writes per register.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `halt` in 1: freezes all state. Forces `issue_ready` low.
- `issue_valid` in 1: the issue stage presents an instruction.
- `issue_rd` in 5, `issue_rd_we` in 1: destination register and its write enable.
- `issue_rs1` in 5, `issue_rs1_used` in 1: source 1 register and its use flag.
- `issue_rs2` in 5, `issue_rs2_used` in 1: source 2 register and its use flag.
- `issue_ready` out 1: combinational. Issue is allowed this cycle.
- `wb_valid` in 1, `wb_rd` in 5: a register write reaches the register file this cycle.
- `kill_valid` in 1, `kill_rd` in 5: a squashed in-flight writer of `kill_rd` that will never write back.
- `busy` out NREG: registered. Bit i is 1 when cnt[i] != 0. Bit 0 is always 0.
- `stall_count` out 16: registered, saturating count of stall cycles.
- `err_underflow` out 1: registered, sticky. Set on a retire when the target counter is 0.

## Operation

- **Per-register counters.** Each register i in 1..NREG-1 has a counter cnt[i] of width CNT_W. x0 is never tracked: issue, wb or kill to x0 has no effect.
- **Source hazard.** hz_rsN = issue_rsN_used && issue_rsN != 0 && cnt[issue_rsN] != 0.
- **Saturation hazard.** hz_sat = issue_rd_we && issue_rd != 0 && cnt[issue_rd] == 2^CNT_W-1.
- **Ready.** issue_ready = !halt && !hz_rs1 && !hz_rs2 && !hz_sat. It is independent of `issue_valid`.
- **Fire.** fire = issue_valid && issue_ready. On fire with issue_rd_we && issue_rd != 0, inc[issue_rd] = 1.
- **Retire.** dec[r] = (wb_valid && wb_rd == r) + (kill_valid && kill_rd == r), which is 0, 1 or 2.
- **Next count.** cnt'[r] = cnt[r] + inc[r] - dec[r], computed in CNT_W+1 bits.
  - If cnt[r] + inc[r] < dec[r]: cnt'[r] = 0 and err_underflow is set.
- **Simultaneous issue and retire on the same r.** Net change is applied, e.g. +1-1 = unchanged.
  - Saturation is evaluated against the current cnt, so a retire in the same cycle does not unblock a saturated issue.
- **Stall counter.** stall_count increments when issue_valid && !issue_ready && !halt, saturating at 0xFFFF.
- **Halt.** While halt is high, no counter, `stall_count` or `err_underflow` update occurs. wb and kill inputs are ignored; upstream holds them.
- **err_underflow** clears only on reset.

## Timing

- **Reset (asynchronous).** On reset assertion, immediately:
  - all cnt = 0, so busy = 0
  - stall_count = 0
  - err_underflow = 0
  - issue_ready = !halt, since no hazards remain
- **Reset mid-operation.** All pending writes are discarded. Later wb/kill for them set err_underflow.
- **issue_ready latency.** Combinational, same cycle, from issue_* inputs and current counters.
- **Counter and busy latency.** Counters and `busy` update one cycle after the fire/wb/kill edge.
- **Back-to-back dependency.** With instruction A writing x5 and the next instruction B reading x5:
  - B stalls from the cycle after A fires.
  - B stalls until the cycle after A's wb, or the wb cycle itself with SCOREBOARD_BYPASS_EN.
- **Register-file bypass.** The register file forwards a same-cycle write, so a read in the wb cycle returns correct data.

## Configuration

- **`SCOREBOARD_BYPASS_EN`** controls whether a write-back in the current cycle clears a source hazard.
- **Defined.** A source register r is not a hazard when cnt[r] == 1 && wb_valid && wb_rd == r. This exploits the register file's same-cycle write bypass and saves one stall cycle per RAW dependency.
- **Undefined.** Any cnt[r] != 0 is a hazard. Issue resumes the cycle after the counter reaches 0.
- **Unaffected.** Kill never clears a hazard early in either build.

## Test plan

- **Reset.** Assert reset mid-cycle with cnt[x5] = 2 -> busy = 0, stall_count = 0 and err_underflow = 0 immediately, before the next clock edge.
- **RAW stall.** Issue x5 write, then the next instruction reads rs1 = x5; wb x5 three cycles later -> issue_ready low for 3 cycles without the macro, 2 cycles with it; stall_count = 3 or 2 respectively.
- **x0 ignored.** Issue with rd = x0, then read rs1 = x0; wb_rd = 0 with cnt all zero -> issue_ready stays high, busy = 0, err_underflow stays 0.
- **Saturation and simultaneous events.** Three writes to x7 (CNT_W = 2), then a fourth issue -> issue_ready low. Same cycle wb x7 -> cnt 3 -> 2, and the fourth issues on the next cycle. Then wb x7 and kill x7 together -> cnt 2 -> 0.
- **Underflow.** kill_rd = x9 with cnt[x9] = 0 -> cnt stays 0, err_underflow = 1 and sticky until reset.
- **Halt.** Hold halt for 4 cycles during a pending x3 wb -> issue_ready = 0, and cnt, busy and stall_count stay unchanged throughout.
